// File: rtl/izh_cordic_array.sv
// rtl/izh_cordic_array.sv - time-multiplexed Izhikevich neuron array with shift-add CORDIC squarer
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset (aborts any running step)
//   step_valid/ready    step handshake; ready only while idle
//   cur_in  [16N]       signed input current per neuron, lane k at [16k+15:16k]
//   q_in    [8N]        signed Q4.4 operand per neuron, squared by linear-mode CORDIC
//   neur_en [N]         per-neuron update enable
//   v_out   [16N]       stored membrane potential of every neuron
//   spike   [N]         spike flags of the last completed step
//   done                one-cycle pulse when a step completes
module izh_cordic_array #(
    parameter int N_NEUR = 4,
    parameter int ITER = 9,
    parameter logic signed [15:0] C = -16'sd3328,
    parameter logic signed [15:0] D = 16'sd1024,
    parameter logic signed [15:0] V_TH = 16'sd1536,
    parameter logic signed [15:0] V_MIN = -16'sd4096,
    parameter logic signed [15:0] U_RST = -16'sd832
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_valid,
    output logic                 step_ready,
    input  logic [16*N_NEUR-1:0] cur_in,
    input  logic [8*N_NEUR-1:0]  q_in,
    input  logic [N_NEUR-1:0]    neur_en,
    output logic [16*N_NEUR-1:0] v_out,
    output logic [N_NEUR-1:0]    spike,
    output logic                 done
);
    localparam int IW = (N_NEUR > 1) ? $clog2(N_NEUR) : 1;
    localparam logic [3:0] ITER_L = 4'(ITER);
    localparam logic [IW-1:0] LAST = IW'(N_NEUR - 1);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ITER, S_UPDATE, S_SKIP, S_DONE} state_t;
    state_t state, state_nx;

    logic [IW-1:0]         idx;
    logic [3:0]            it;
    logic [16*N_NEUR-1:0]  cur_l;
    logic [8*N_NEUR-1:0]   q_l;
    logic [N_NEUR-1:0]     en_l;
    logic signed [15:0]    v_r [N_NEUR];
    logic signed [15:0]    u_r [N_NEUR];
    logic signed [17:0]    y, zr, xs;

    logic                  last, en_next;
    logic [IW:0]           nidx;
    logic [N_NEUR-1:0]     nmask;
    logic [7:0]            q_cur;
    logic signed [17:0]    ang, y_nx, zr_nx;
    logic signed [15:0]    sq, v_cur, u_cur, i_cur, v_new, u_new;
    logic signed [31:0]    sq32, v32, u32, i32, vmin32, dv, vn, du;
    logic                  fire;

    // Enable of the following neuron; the mask shifts out to zero past the last lane.
    always_comb begin
        last    = (idx == LAST);
        nidx    = {1'b0, idx} + {{IW{1'b0}}, 1'b1};
        nmask   = N_NEUR'(1) << nidx;
        en_next = |(en_l & nmask);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        step_ready = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                step_ready = 1'b1;
                if (step_valid) state_nx = neur_en[0] ? S_INIT : S_SKIP;
            end
            S_INIT:   state_nx = S_ITER;
            S_ITER:   if (it == ITER_L) state_nx = S_UPDATE;
            S_UPDATE,
            S_SKIP:   state_nx = last ? S_DONE : (en_next ? S_INIT : S_SKIP);
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    // Linear-mode CORDIC: y accumulates xs * zr / 256, with zr holding q as a Q8 fraction
    // and xs holding q scaled by 256, so y converges to q*q in Q8.
    always_comb begin
        q_cur = q_l[8*idx +: 8];
        ang   = 18'sd256 >>> it;
        y_nx  = y;
        zr_nx = zr;
        if (!zr[17]) begin
            y_nx  = y + (xs >>> it);
            zr_nx = zr - ang;
        end else begin
            y_nx  = y - (xs >>> it);
            zr_nx = zr + ang;
        end
    end

    // Neuron update arithmetic in 32-bit signed; du uses the pre-update v.
    always_comb begin
        if (y > 18'sd32767)       sq = 16'sh7fff;
        else if (y < -18'sd32768) sq = 16'sh8000;
        else                      sq = y[15:0];
        v_cur  = v_r[idx];
        u_cur  = u_r[idx];
        i_cur  = cur_l[16*idx +: 16];
        sq32   = {{16{sq[15]}}, sq};
        v32    = {{16{v_cur[15]}}, v_cur};
        u32    = {{16{u_cur[15]}}, u_cur};
        i32    = {{16{i_cur[15]}}, i_cur};
        vmin32 = {{16{V_MIN[15]}}, V_MIN};
        fire   = (v_cur >= V_TH);
        dv     = (sq32 >>> 1) + 5 * v32 + 32'sd7168 - u32 + i32;
        vn     = v32 + (dv >>> 5);
        du     = ((v32 >>> 2) - u32) >>> 6;
        v_new  = 16'((vn < vmin32) ? vmin32 : vn);
        u_new  = u_cur + 16'(du >>> 5);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            it    <= '0;
            cur_l <= '0;
            q_l   <= '0;
            en_l  <= '0;
            spike <= '0;
            y     <= '0;
            zr    <= '0;
            xs    <= '0;
            for (int k = 0; k < N_NEUR; k++) begin
                v_r[k] <= C;
                u_r[k] <= U_RST;
            end
        end else begin
            case (state)
                S_IDLE: if (step_valid) begin
                    cur_l <= cur_in;
                    q_l   <= q_in;
                    en_l  <= neur_en;
                    spike <= '0;
                    idx   <= '0;
                end
                S_INIT: begin
                    y  <= '0;
                    zr <= {{10{q_cur[7]}}, q_cur};
                    xs <= {{2{q_cur[7]}}, q_cur, 8'h00};
                    it <= 4'd1;
                end
                S_ITER: begin
                    y  <= y_nx;
                    zr <= zr_nx;
                    it <= it + 4'd1;
                end
                S_UPDATE: begin
                    if (fire) begin
                        v_r[idx] <= C;
                        u_r[idx] <= u_cur + D;
                    end else begin
                        v_r[idx] <= v_new;
                        u_r[idx] <= u_new;
                    end
                    spike[idx] <= fire;
                    if (!last) idx <= idx + 1'b1;
                end
                S_SKIP: begin
                    spike[idx] <= 1'b0;
                    if (!last) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < N_NEUR; k++) begin : g_vout
        assign v_out[16*k +: 16] = v_r[k];
    end
endmodule

// File: tb/tb_izh_cordic_array.sv
// tb/tb_izh_cordic_array.sv - scoreboard bench for izh_cordic_array
module tb_izh_cordic_array;
    localparam int N = 4;
    localparam int IT = 9;

    logic            clk = 1'b0;
    logic            rst_n, step_valid, step_ready, done;
    logic [16*N-1:0] cur_in, v_out;
    logic [8*N-1:0]  q_in;
    logic [N-1:0]    neur_en, spike;

    izh_cordic_array #(.N_NEUR(N), .ITER(IT)) dut (
        .clk(clk), .rst_n(rst_n), .step_valid(step_valid), .step_ready(step_ready),
        .cur_in(cur_in), .q_in(q_in), .neur_en(neur_en),
        .v_out(v_out), .spike(spike), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16*N-1:0] v;
        logic [N-1:0]    sp;
        int              lat;
    } exp_t;

    exp_t sb[$];
    int   mv[N];
    int   mu[N];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic int s16(input int x);
        logic signed [15:0] t;
        t = x[15:0];
        return int'(t);
    endfunction

    function automatic int s8(input logic [7:0] x);
        logic signed [7:0] t;
        t = x;
        return int'(t);
    endfunction

    function automatic int cordic_sq(input int q);
        int y, zr, xs;
        y = 0; zr = q; xs = q * 256;
        for (int i = 1; i <= IT; i++) begin
            if (zr >= 0) begin y = y + (xs >>> i); zr = zr - (256 >>> i); end
            else         begin y = y - (xs >>> i); zr = zr + (256 >>> i); end
        end
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return y;
    endfunction

    function automatic int lane(input int k);
        return s16(int'(v_out[16*k +: 16]));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin mv[k] = -3328; mu[k] = -832; end
    endtask

    task automatic model_step(input logic [16*N-1:0] cur, input logic [8*N-1:0] q,
                              input logic [N-1:0] en, output exp_t e);
        int sq, ik, dv, vn, du;
        e.sp = '0;
        e.lat = 1;
        for (int k = 0; k < N; k++) begin
            if (en[k]) begin
                e.lat += IT + 2;
                sq = cordic_sq(s8(q[8*k +: 8]));
                ik = s16(int'(cur[16*k +: 16]));
                if (mv[k] >= 1536) begin
                    mv[k] = -3328;
                    mu[k] = s16(mu[k] + 1024);
                    e.sp[k] = 1'b1;
                end else begin
                    dv = (sq >>> 1) + 5 * mv[k] + 7168 - mu[k] + ik;
                    vn = mv[k] + (dv >>> 5);
                    du = ((mv[k] >>> 2) - mu[k]) >>> 6;
                    if (vn < -4096) vn = -4096;
                    mu[k] = s16(mu[k] + (du >>> 5));
                    mv[k] = s16(vn);
                end
            end else begin
                e.lat += 1;
            end
            e.v[16*k +: 16] = mv[k][15:0];
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        step_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_step(input logic [16*N-1:0] cur, input logic [8*N-1:0] q,
                            input logic [N-1:0] en, input bit hold, input bit chained);
        exp_t e;
        int   cnt, busy_ready;
        bit   got;
        model_step(cur, q, en, e);
        sb.push_back(e);
        if (!chained) begin
            @(negedge clk);
            cur_in = cur; q_in = q; neur_en = en; step_valid = 1'b1;
        end
        @(posedge clk); #1;
        vectors++;
        if (step_ready !== 1'b0) begin
            miscompares++; $display("FAIL accept: step_ready=%b expected 0", step_ready);
        end
        vectors++;
        if (spike !== '0) begin
            miscompares++; $display("FAIL spike_clear: got %b expected 0", spike);
        end
        if (!hold) begin
            step_valid = 1'b0;
            cur_in = {$urandom, $urandom};
            q_in = $urandom;
            neur_en = ~en;
        end
        cnt = 1; got = 1'b0; busy_ready = 0;
        while (!got && cnt < 400) begin
            @(posedge clk); cnt++; #1;
            if (done) got = 1'b1;
            else if (step_ready) busy_ready++;
        end
        e = sb.pop_front();
        vectors++;
        if (!got || cnt != e.lat) begin
            miscompares++; $display("FAIL latency: got %0d (done seen %b) expected %0d", cnt, got, e.lat);
        end
        vectors++;
        if (v_out !== e.v) begin
            miscompares++; $display("FAIL v_out: got %h expected %h", v_out, e.v);
        end
        vectors++;
        if (spike !== e.sp) begin
            miscompares++; $display("FAIL spike: got %b expected %b", spike, e.sp);
        end
        vectors++;
        if (busy_ready != 0) begin
            miscompares++; $display("FAIL busy_ready: got %0d ready cycles expected 0", busy_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || step_ready !== 1'b1) begin
            miscompares++; $display("FAIL done_pulse: done=%b ready=%b expected 0/1", done, step_ready);
        end
    endtask

    task automatic test_reset();
        logic [16*N-1:0] exp_v;
        do_reset(2);
        exp_v = {N{16'hF300}};
        vectors++;
        if (v_out !== exp_v) begin miscompares++; $display("FAIL reset_v: got %h expected %h", v_out, exp_v); end
        vectors++;
        if (spike !== '0) begin miscompares++; $display("FAIL reset_spike: got %b expected 0", spike); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++;
        if (step_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", step_ready); end
    endtask

    task automatic test_defaults();
        do_reset(2);
        run_step('0, '0, 4'hF, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (lane(k) != -3598) begin miscompares++; $display("FAIL default_lane%0d: got %0d expected -3598", k, lane(k)); end
        end
    endtask

    task automatic test_cordic_q();
        do_reset(2);
        run_step('0, 32'h0000_0010, 4'hF, 1'b0, 1'b0);
        vectors++;
        if (lane(0) != -3594) begin miscompares++; $display("FAIL q_one_lane0: got %0d expected -3594", lane(0)); end
        vectors++;
        if (lane(1) != -3598) begin miscompares++; $display("FAIL q_one_lane1: got %0d expected -3598", lane(1)); end
    endtask

    task automatic test_spike();
        bit seen, will;
        do_reset(2);
        seen = 1'b0;
        for (int s = 0; s < 30 && !seen; s++) begin
            will = (mv[0] >= 1536);
            run_step({48'h0, 16'h7fff}, '0, 4'hF, 1'b0, 1'b0);
            if (s == 0) begin
                vectors++;
                if (lane(0) != -2575) begin miscompares++; $display("FAIL drive_first: got %0d expected -2575", lane(0)); end
            end
            if (will) begin
                seen = 1'b1;
                vectors++;
                if (spike !== 4'b0001 || lane(0) != -3328) begin
                    miscompares++; $display("FAIL spike_fire: spike=%b v0=%0d expected 0001/-3328", spike, lane(0));
                end
            end
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL spike_reached: got no threshold crossing expected one"); end
        run_step({48'h0, 16'h7fff}, '0, 4'hF, 1'b0, 1'b0);
    endtask

    task automatic test_clamp();
        do_reset(2);
        run_step({32'h0, 16'h8000, 16'h0}, '0, 4'hF, 1'b0, 1'b0);
        vectors++;
        if (lane(1) != -4096) begin miscompares++; $display("FAIL clamp_lane1: got %0d expected -4096", lane(1)); end
    endtask

    task automatic test_back_to_back();
        do_reset(2);
        run_step({4{16'h1234}}, 32'h2030_4050, 4'b0101, 1'b1, 1'b0);
        vectors++;
        if (lane(1) != -3328 || lane(3) != -3328) begin
            miscompares++; $display("FAIL skip_hold: got %0d/%0d expected -3328/-3328", lane(1), lane(3));
        end
        run_step({4{16'h1234}}, 32'h2030_4050, 4'b0101, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset();
        int pulses;
        do_reset(2);
        @(negedge clk);
        cur_in = {4{16'h7fff}}; q_in = '0; neur_en = 4'hF; step_valid = 1'b1;
        @(posedge clk); #1;
        step_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        vectors++;
        if (v_out !== {N{16'hF300}} || spike !== '0 || done !== 1'b0 || step_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: v=%h spike=%b done=%b ready=%b expected f300s/0/0/1", v_out, spike, done, step_ready);
        end
        pulses = 0;
        repeat (60) begin @(posedge clk); #1; if (done) pulses++; end
        vectors++;
        if (pulses != 0) begin miscompares++; $display("FAIL mid_reset_done: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_random();
        logic [16*N-1:0] c;
        logic [8*N-1:0]  q;
        logic [N-1:0]    en;
        do_reset(2);
        for (int s = 0; s < 6; s++) begin
            for (int k = 0; k < N; k++) c[16*k +: 16] = 16'($urandom_range(0, 24000)) - 16'd8000;
            q  = $urandom;
            en = N'($urandom);
            run_step(c, q, en, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; step_valid = 1'b0; cur_in = '0; q_in = '0; neur_en = '0;
        model_reset();
        test_reset();
        test_defaults();
        test_cordic_q();
        test_spike();
        test_clamp();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/izh_cordic_array.md
IZH_CORDIC_ARRAY -- requirements
Module: izh_cordic_array

Interface
REQ-001 SHALL have parameter N_NEUR, default 4, number of time-multiplexed neurons (legal 1..64).
REQ-002 SHALL have parameter ITER, default 9, CORDIC iterations per multiply (legal 1..15).
REQ-003 SHALL have parameters C=-3328, D=1024, V_TH=1536, V_MIN=-4096, U_RST=-832, all signed 16-bit: reset v, spike u-increment, threshold, v floor, reset u.
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port step_valid  in  1  request one network step.
REQ-006 SHALL have port step_ready  out  1  high only when IDLE; a step is accepted on step_valid&&step_ready.
REQ-007 SHALL have port cur_in  in  16*N_NEUR  packed signed input current; neuron k in bits [16k+15:16k].
REQ-008 SHALL have port q_in  in  8*N_NEUR  packed signed Q4.4 multiplier operand per neuron.
REQ-009 SHALL have port neur_en  in  N_NEUR  per-neuron update enable.
REQ-010 SHALL have port v_out  out  16*N_NEUR  packed stored v of every neuron.
REQ-011 SHALL have port spike  out  N_NEUR  spike flags of the last completed step.
REQ-012 SHALL have port done  out  1  one-cycle pulse at step completion.

Function
REQ-013 SHALL latch cur_in, q_in, neur_en on acceptance; later input changes SHALL not affect the running step.
REQ-014 SHALL use FSM IDLE -> INIT -> ITER -> UPDATE -> (INIT of next neuron | DONE) -> IDLE, neurons processed k=0..N_NEUR-1 in order.
REQ-015 Disabled neuron (latched neur_en[k]=0) SHALL spend exactly one SKIP cycle instead of INIT/ITER/UPDATE; v,u held; spike[k]=0.
REQ-016 Enabled neuron SHALL take 1 INIT + ITER + 1 UPDATE cycles; DONE lasts 1 cycle asserting done; latency accept->done = En*(ITER+2)+(N_NEUR-En)+1 cycles.
REQ-017 CORDIC INIT: y=0, zr=sign-extended q (Q8 view), xs=sign-extended q<<8; accumulators 18-bit signed.
REQ-018 CORDIC iteration i=1..ITER: zr>=0 -> y+=xs>>>i, zr-=256>>>i; else y-=xs>>>i, zr+=256>>>i; exact adders.
REQ-019 Product sq = y saturated to signed 16-bit (approx q_int*q_int, Q8 of q^2).
REQ-020 UPDATE, if v>=V_TH: v<=C, u<=u+D (16-bit wrap), spike[k]=1.
REQ-021 UPDATE, else (32-bit signed): dv=(sq>>>1)+5v+7168-u+I; v_new=v+(dv>>>5); v<=max(v_new,V_MIN) truncated to 16 bits; du=((v>>>2)-u)>>>6; u<=u+(du>>>5); old v used for du; spike[k]=0.
REQ-022 spike SHALL be cleared to 0 on acceptance and written per neuron at its UPDATE/SKIP; held after DONE until next acceptance.
REQ-023 step_valid while not IDLE SHALL be ignored (no queuing).
REQ-024 v_out SHALL reflect stored v registers combinationally, updating at each UPDATE.

Reset
REQ-025 rst_n=0 at any clock edge, including mid-step, SHALL abort the step: FSM IDLE, all v=C, all u=U_RST, spike=0, done=0, step_ready=1 the following cycle.

Verification
REQ-026 Reset: rst_n low 2 cycles -> every v_out lane -3328, spike 0, done 0, step_ready 1.
REQ-027 Defaults, all en, q=0, I=0, one step -> every v_out -3598, u unchanged -832, done exactly 45 cycles after accept, spike 0.
REQ-028 q[0]=16 (1.0), I=0 -> sq in [248,264], v_out[0] in [-3595,-3593]; others -3598.
REQ-029 I[0]=32767 repeated steps -> first step v_out[0]=-2575; step after v_out[0]>=1536 gives spike[0]=1, v_out[0]=-3328, u[0]+=1024, other spikes 0.
REQ-030 I[1]=-32768 from reset -> v_out[1] clamped to -4096 (unclamped -4622).
REQ-031 neur_en=4'b0101, step_valid held high -> one accept, lanes 1,3 unchanged, done 25 cycles after accept, re-accept only after IDLE; rst_n low 10 cycles into a step -> reset values, no done.
